// File: rtl/pia_dsp_ctrl.sv
// rtl/pia_dsp_ctrl.sv - display-register to terminal-host character bridge with FIFO
//
// Characters from the display register are buffered in a FIFO and offered to
// the terminal host. Both sides use a four-phase rdy/ack handshake.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   dsp_rdy     display register holds a new character
//   dsp_data    7-bit ASCII character, valid while dsp_rdy=1
//   dsp_ack     acknowledge back to the display register
//   host_rdy    character offered to the host
//   host_data   7-bit ASCII character, stable while host_rdy=1
//   host_ack    host acknowledge
//   fifo_count  FIFO entries in use, 0..2**DEPTH_LOG2
//   overrun     sticky; set when dsp_rdy is held off by a full FIFO
//
// Build option:
//   PIA_DSP_CRLF_EN  when defined, every 0x0D delivered to the host is
//                    followed by a generated 0x0A (H_LF state).

module pia_dsp_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dsp_rdy,
  input  logic [6:0]            dsp_data,
  output logic                  dsp_ack,
  output logic                  host_rdy,
  output logic [6:0]            host_data,
  input  logic                  host_ack,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic {
    P_IDLE,
    P_ACK
  } p_state_t;

`ifdef PIA_DSP_CRLF_EN
  typedef enum logic [1:0] {
    H_IDLE,
    H_WAIT,
    H_REL,
    H_LF
  } h_state_t;

  localparam logic [6:0] CHAR_CR = 7'h0D;
  localparam logic [6:0] CHAR_LF = 7'h0A;
`else
  typedef enum logic [1:0] {
    H_IDLE,
    H_WAIT,
    H_REL
  } h_state_t;
`endif

  p_state_t p_state;
  h_state_t h_state;

  // Character storage; contents need no reset since fifo_count gates all reads.
  logic [6:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

`ifdef PIA_DSP_CRLF_EN
  logic                  lf_pending;
`endif

  // fifo_count never exceeds DEPTH, so its MSB alone marks the full state.
  assign fifo_full  = fifo_count[DEPTH_LOG2];
  assign fifo_empty = (fifo_count == '0);

  // A character is written only on the P_IDLE edge that accepts it; holding
  // dsp_rdy high afterwards (P_ACK) never writes again.
  assign push = (p_state == P_IDLE) && dsp_rdy && !fifo_full;

  // The head entry is retired on the edge the host acknowledges it. The
  // generated line feed is not a FIFO entry, so H_LF never pops.
  assign pop  = (h_state == H_WAIT) && host_ack && !fifo_empty;

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dsp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Display-side handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      p_state <= P_IDLE;
      dsp_ack <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (dsp_rdy) begin
            if (!fifo_full) begin
              dsp_ack <= 1'b1;
              p_state <= P_ACK;
            end else begin
              // Leave the display register waiting and remember that it had to.
              overrun <= 1'b1;
            end
          end
        end
        P_ACK: begin
          if (!dsp_rdy) begin
            dsp_ack <= 1'b0;
            p_state <= P_IDLE;
          end
        end
        default: begin
          dsp_ack <= 1'b0;
          p_state <= P_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Host-side handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      h_state   <= H_IDLE;
      host_rdy  <= 1'b0;
      host_data <= '0;
`ifdef PIA_DSP_CRLF_EN
      lf_pending <= 1'b0;
`endif
    end else begin
      case (h_state)
        H_IDLE: begin
          // host_data is captured here and held until the pop, so later
          // FIFO writes cannot disturb the character on offer.
          if (!fifo_empty) begin
            host_data <= mem[rd_ptr];
            host_rdy  <= 1'b1;
            h_state   <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (host_ack) begin
            host_rdy <= 1'b0;
            h_state  <= H_REL;
`ifdef PIA_DSP_CRLF_EN
            lf_pending <= (host_data == CHAR_CR);
`endif
          end
        end
        H_REL: begin
          if (!host_ack) begin
`ifdef PIA_DSP_CRLF_EN
            if (lf_pending) begin
              host_data  <= CHAR_LF;
              host_rdy   <= 1'b1;
              lf_pending <= 1'b0;
              h_state    <= H_LF;
            end else begin
              h_state <= H_IDLE;
            end
`else
            h_state <= H_IDLE;
`endif
          end
        end
`ifdef PIA_DSP_CRLF_EN
        H_LF: begin
          // Same handshake as H_WAIT; H_REL then finds lf_pending clear.
          if (host_ack) begin
            host_rdy <= 1'b0;
            h_state  <= H_REL;
          end
        end
`endif
        default: begin
          host_rdy <= 1'b0;
          h_state  <= H_IDLE;
        end
      endcase
    end
  end

endmodule
